// File: rtl/aes_keysched_if.sv
// Round-key bus between the AES-128 round controller and the key scheduler.
//   keyld/keyin    : byte-serial cipher key load, MSB first
//   start/encdec   : begin an operation (0 = encryption, 1 = decryption)
//   next           : advance to the following round key
//   roundkey/round : current round key and its index
//   keyready/busy  : key valid / decryption pre-walk in progress
interface aes_keysched_if;
  localparam int unsigned KEY_W   = 128;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned ROUND_W = 4;

  logic                keyld;
  logic [BYTE_W-1:0]   keyin;
  logic                start;
  logic                encdec;
  logic                next;
  logic [KEY_W-1:0]    roundkey;
  logic [ROUND_W-1:0]  round;
  logic                keyready;
  logic                busy;

  // Round controller side.
  modport master (
    output keyld, keyin, start, encdec, next,
    input  roundkey, round, keyready, busy
  );

  // Key scheduler side.
  modport slave (
    input  keyld, keyin, start, encdec, next,
    output roundkey, round, keyready, busy
  );
endinterface

// File: rtl/aes_keysched.sv
// AES-128 round-key generator for the byte-serial datapath.
// Loads the cipher key byte-serially, then steps round keys forward
// (K0..K10) or backward (K10..K0) one per `next` pulse. Decryption first
// walks forward to K10 (busy high), then steps backward on demand.
//   clk   : system clock, rising edge
//   rst   : asynchronous reset, active-low
//   kif   : aes_keysched_if.slave (load, control and round-key outputs)

// Forward AES S-box, one byte lookup.
module sbox_mux (
  input  logic [7:0] din,
  output logic [7:0] dout
);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign dout = SBOX[din];
endmodule

module aes_keysched #(
  parameter int unsigned NROUND = 10
) (
  input  logic           clk,
  input  logic           rst,
  aes_keysched_if.slave  kif
);
  localparam int unsigned KEY_W   = 128;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned ROUND_W = 4;
  localparam int unsigned CNT_W   = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WALK,
    S_READY
  } state_t;

  state_t              state_q, state_d;
  logic [KEY_W-1:0]    key_q, key_d;
  logic [KEY_W-1:0]    k0_q, k0_d;
  logic [ROUND_W-1:0]  round_q, round_d;
  logic [BYTE_W-1:0]   rcon_q, rcon_d;
  logic                mode_q, mode_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                keyready_q, keyready_d;
  logic                busy_q, busy_d;

  // Key words of the current round key.
  logic [WORD_W-1:0] w0, w1, w2, w3;
  assign w0 = key_q[127:96];
  assign w1 = key_q[95:64];
  assign w2 = key_q[63:32];
  assign w3 = key_q[31:0];

  // rcon_q holds Rcon for the next forward step (Rcon[round+1]); the
  // inverse step needs Rcon[round], one inverse-xtime back.
  logic [BYTE_W-1:0] rcon_fwd_c, rcon_inv_c;
  assign rcon_fwd_c = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
  assign rcon_inv_c = rcon_q[0] ? ({1'b0, rcon_q[7:1] ^ 7'h0d} | 8'h80)
                                : {1'b0, rcon_q[7:1]};

  // The four S-boxes are shared: forward steps substitute w3, inverse
  // steps substitute the recovered w3' = w3 ^ w2.
  logic              inv_sel_c;
  logic [WORD_W-1:0] w3x_c, sb_in_c, rot_c, sub_c;
  assign inv_sel_c = (state_q == S_READY) && mode_q;
  assign w3x_c     = w3 ^ w2;
  assign sb_in_c   = inv_sel_c ? w3x_c : w3;
  assign rot_c     = {sb_in_c[23:0], sb_in_c[31:24]};

  sbox_mux u_sbox0 (.din(rot_c[31:24]), .dout(sub_c[31:24]));
  sbox_mux u_sbox1 (.din(rot_c[23:16]), .dout(sub_c[23:16]));
  sbox_mux u_sbox2 (.din(rot_c[15:8]),  .dout(sub_c[15:8]));
  sbox_mux u_sbox3 (.din(rot_c[7:0]),   .dout(sub_c[7:0]));

  // Forward step: round r -> r+1.
  logic [WORD_W-1:0] f0_c, f1_c, f2_c, f3_c;
  assign f0_c = w0 ^ sub_c ^ {rcon_q, 24'h0};
  assign f1_c = w1 ^ f0_c;
  assign f2_c = w2 ^ f1_c;
  assign f3_c = w3 ^ f2_c;

  // Inverse step: round r -> r-1.
  logic [WORD_W-1:0] i0_c, i1_c, i2_c, i3_c;
  assign i3_c = w3x_c;
  assign i2_c = w2 ^ w1;
  assign i1_c = w1 ^ w0;
  assign i0_c = w0 ^ sub_c ^ {rcon_inv_c, 24'h0};

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      key_q      <= '0;
      k0_q       <= '0;
      round_q    <= '0;
      rcon_q     <= 8'h01;
      mode_q     <= 1'b0;
      cnt_q      <= '0;
      keyready_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      k0_q       <= k0_d;
      round_q    <= round_d;
      rcon_q     <= rcon_d;
      mode_q     <= mode_d;
      cnt_q      <= cnt_d;
      keyready_q <= keyready_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state logic; priority keyld > start > next, nothing accepted in WALK.
  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    k0_d       = k0_q;
    round_d    = round_q;
    rcon_d     = rcon_q;
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    keyready_d = keyready_q;
    busy_d     = busy_q;

    case (state_q)
      S_IDLE, S_LOAD, S_READY: begin
        if (kif.keyld) begin
          key_d      = {key_q[119:0], kif.keyin};
          k0_d       = {k0_q[119:0], kif.keyin};
          cnt_d      = cnt_q + CNT_W'(1);
          keyready_d = 1'b0;
          state_d    = (cnt_q == CNT_W'(15)) ? S_IDLE : S_LOAD;
        end else if (kif.start) begin
          // Every operation begins from the loaded K0.
          key_d   = k0_q;
          round_d = '0;
          rcon_d  = 8'h01;
          mode_d  = kif.encdec;
          cnt_d   = '0;
          if (kif.encdec) begin
            busy_d     = 1'b1;
            keyready_d = 1'b0;
            state_d    = S_WALK;
          end else begin
            keyready_d = 1'b1;
            state_d    = S_READY;
          end
        end else if (kif.next && (state_q == S_READY)) begin
          if (!mode_q && (round_q < ROUND_W'(NROUND))) begin
            key_d   = {f0_c, f1_c, f2_c, f3_c};
            round_d = round_q + ROUND_W'(1);
            rcon_d  = rcon_fwd_c;
          end else if (mode_q && (round_q != '0)) begin
            key_d   = {i0_c, i1_c, i2_c, i3_c};
            round_d = round_q - ROUND_W'(1);
            rcon_d  = rcon_inv_c;
          end
        end
      end

      S_WALK: begin
        // Decryption pre-walk: one forward step per cycle up to K10.
        key_d   = {f0_c, f1_c, f2_c, f3_c};
        round_d = round_q + ROUND_W'(1);
        rcon_d  = rcon_fwd_c;
        if (round_q == ROUND_W'(NROUND - 1)) begin
          busy_d     = 1'b0;
          keyready_d = 1'b1;
          state_d    = S_READY;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign kif.roundkey = key_q;
  assign kif.round    = round_q;
  assign kif.keyready = keyready_q;
  assign kif.busy     = busy_q;
endmodule

// File: tb/tb_aes_keysched.sv
// Self-checking bench for aes_keysched: directed FIPS-197 vectors, priority
// and partial-load sequences, async reset mid-walk, and a random-key round
// trip against an independent key-expansion model.
module tb_aes_keysched;
  logic clk = 1'b0;
  logic rst = 1'b0;

  aes_keysched_if kif ();

  aes_keysched #(.NROUND(10)) dut (
    .clk (clk),
    .rst (rst),
    .kif (kif)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  localparam logic [127:0] KA   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KA1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] KA2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] KA10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KB   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KB1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] KB10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  typedef struct {
    logic [127:0] key;
    logic         ed;
    int           nnext;
    logic [127:0] exp_rk;
    logic [3:0]   exp_round;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  // Reference model: S-box derived from GF(2^8) inverse + affine map.
  logic [7:0]   sb [256];
  logic [127:0] mk [11];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0)
        for (int b = 1; b < 256; b++)
          if (gmul(8'(x), 8'(b)) == 8'h01) inv = 8'(b);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
          {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sb[x] = s;
    end
  endtask

  // Textbook FIPS-197 key expansion into mk[0..10].
  task automatic expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) mk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic chk128(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_bytes(input logic [127:0] k, input int n);
    for (int i = 0; i < n; i++) begin
      kif.keyld = 1'b1;
      kif.keyin = k[127 - 8*i -: 8];
      cyc();
    end
    kif.keyld = 1'b0;
  endtask

  task automatic do_start(input logic ed);
    kif.start  = 1'b1;
    kif.encdec = ed;
    cyc();
    kif.start  = 1'b0;
    kif.encdec = 1'b0;
  endtask

  task automatic do_next();
    kif.next = 1'b1;
    cyc();
    kif.next = 1'b0;
  endtask

  // Bounded wait for keyready; a timeout is a failed comparison.
  task automatic wait_ready(input string nm);
    for (int i = 0; i < 30 && !kif.keyready; i++) cyc();
    chk32({nm, "_ready"}, 32'(kif.keyready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int nb, first;
    logic [127:0] rk;

    kif.keyld  = 1'b0;
    kif.keyin  = 8'h00;
    kif.start  = 1'b0;
    kif.encdec = 1'b0;
    kif.next   = 1'b0;

    vecs[0]  = '{KA, 1'b0, 0,  KA,   4'd0};
    vecs[1]  = '{KA, 1'b0, 1,  KA1,  4'd1};
    vecs[2]  = '{KA, 1'b0, 2,  KA2,  4'd2};
    vecs[3]  = '{KA, 1'b0, 10, KA10, 4'd10};
    vecs[4]  = '{KA, 1'b0, 11, KA10, 4'd10};
    vecs[5]  = '{KB, 1'b1, 0,  KB10, 4'd10};
    vecs[6]  = '{KB, 1'b1, 9,  KB1,  4'd1};
    vecs[7]  = '{KB, 1'b1, 10, KB,   4'd0};
    vecs[8]  = '{KB, 1'b1, 11, KB,   4'd0};
    vecs[9]  = '{KA, 1'b1, 8,  KA2,  4'd2};
    vecs[10] = '{KB, 1'b0, 10, KB10, 4'd10};

    build_sbox();

    // Reset values.
    #12;
    chk128("rst_roundkey", kif.roundkey, 128'h0);
    chk32("rst_round", 32'(kif.round), 32'd0);
    chk32("rst_keyready", 32'(kif.keyready), 32'd0);
    chk32("rst_busy", 32'(kif.busy), 32'd0);
    rst = 1'b1;
    cyc();

    // Directed vector table.
    for (int v = 0; v < NV; v++) begin
      load_bytes(vecs[v].key, 16);
      do_start(vecs[v].ed);
      wait_ready($sformatf("vec%0d", v));
      for (int n = 0; n < vecs[v].nnext; n++) do_next();
      chk128($sformatf("vec%0d_roundkey", v), kif.roundkey, vecs[v].exp_rk);
      chk32($sformatf("vec%0d_round", v), 32'(kif.round), 32'(vecs[v].exp_round));
      chk32($sformatf("vec%0d_keyready", v), 32'(kif.keyready), 32'd1);
    end

    // Decryption pre-walk: busy exactly 10 cycles, start mid-walk ignored.
    load_bytes(KB, 16);
    chk32("load_done_keyready", 32'(kif.keyready), 32'd0);
    do_start(1'b1);
    nb = 0;
    first = -1;
    for (int i = 0; i < 15; i++) begin
      if (kif.busy) nb++;
      if (first < 0 && kif.keyready) first = i;
      kif.start  = (i == 3);
      kif.encdec = 1'b0;
      cyc();
    end
    kif.start = 1'b0;
    chk32("walk_busy_cycles", 32'(nb), 32'd10);
    chk32("walk_ready_at", 32'(first), 32'd10);
    chk128("walk_roundkey", kif.roundkey, KB10);
    chk32("walk_round", 32'(kif.round), 32'd10);

    // keyld and next together in READY: load wins, no step.
    load_bytes(KA, 16);
    do_start(1'b0);
    kif.keyld = 1'b1;
    kif.keyin = 8'h55;
    kif.next  = 1'b1;
    cyc();
    kif.keyld = 1'b0;
    kif.next  = 1'b0;
    rk = {KA[119:0], 8'h55};
    chk32("prio_keyready", 32'(kif.keyready), 32'd0);
    chk128("prio_roundkey", kif.roundkey, rk);
    chk32("prio_round", 32'(kif.round), 32'd0);
    do_next();
    chk128("load_next_ignored", kif.roundkey, rk);

    // Partial loads: start uses whatever K0 holds.
    do_start(1'b0);
    chk128("partial1_roundkey", kif.roundkey, rk);
    load_bytes(KA, 16);
    do_start(1'b0);
    chk128("reload_roundkey", kif.roundkey, KA);
    load_bytes(128'h1112131415161718_0000000000000000, 8);
    do_start(1'b0);
    chk128("partial8_roundkey", kif.roundkey, {KA[63:0], 64'h1112131415161718});
    load_bytes(KB, 16);
    do_start(1'b1);
    wait_ready("after_partial");
    chk128("after_partial_roundkey", kif.roundkey, KB10);

    // Asynchronous reset in the middle of the pre-walk.
    load_bytes(KA, 16);
    do_start(1'b1);
    cyc();
    cyc();
    cyc();
    #3;
    rst = 1'b0;
    #1;
    chk128("arst_roundkey", kif.roundkey, 128'h0);
    chk32("arst_busy", 32'(kif.busy), 32'd0);
    chk32("arst_keyready", 32'(kif.keyready), 32'd0);
    chk32("arst_round", 32'(kif.round), 32'd0);
    #12;
    rst = 1'b1;
    cyc();
    cyc();
    chk32("arst_idle_busy", 32'(kif.busy), 32'd0);
    chk32("arst_idle_keyready", 32'(kif.keyready), 32'd0);
    do_start(1'b0);
    chk128("arst_k0_cleared", kif.roundkey, 128'h0);

    // Random-key round trip against the reference model.
    for (int k = 0; k < 50; k++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      expand(rk);
      load_bytes(rk, 16);
      do_start(1'b0);
      chk128($sformatf("rt%0d_enc0", k), kif.roundkey, mk[0]);
      for (int r = 1; r <= 10; r++) begin
        do_next();
        chk128($sformatf("rt%0d_enc%0d", k, r), kif.roundkey, mk[r]);
      end
      do_start(1'b1);
      wait_ready($sformatf("rt%0d", k));
      chk128($sformatf("rt%0d_dec10", k), kif.roundkey, mk[10]);
      for (int r = 9; r >= 0; r--) begin
        do_next();
        chk128($sformatf("rt%0d_dec%0d", k, r), kif.roundkey, mk[r]);
      end
      chk32($sformatf("rt%0d_round", k), 32'(kif.round), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
